// File: rtl/riscv_pkg.sv
// Shared definitions for the write-back stage: RV32I load funct3 encodings
// and the write-back FSM state type.
// No ports; imported by writeback_stage and load_extend.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE,
    WB_WAIT_LOAD
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle of the write-back stage's retire handshake, data-memory return path,
// GPR write port and error flag.
// master: memory stage / data memory / observer side; slave: writeback_stage.
interface writeback_stage_if #(
  parameter int XLEN = 32
);
  // retire handshake from the memory stage
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_result;
  logic            in_is_load;
  logic [2:0]      in_funct3;
  logic [1:0]      in_addr_lo;
  // data-memory read return
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  // GPR write port and status
  logic [4:0]      a3;
  logic            we3;
  logic [XLEN-1:0] wd3;
  logic            err;

  modport master (
    output in_valid, in_rd, in_result, in_is_load, in_funct3, in_addr_lo,
    output mem_rvalid, mem_rdata,
    input  in_ready, a3, we3, wd3, err
  );

  modport slave (
    input  in_valid, in_rd, in_result, in_is_load, in_funct3, in_addr_lo,
    input  mem_rvalid, mem_rdata,
    output in_ready, a3, we3, wd3, err
  );

endinterface

// File: rtl/writeback_stage_load_extend.sv
// Selects the addressed byte/half/word from an aligned read word and sign- or
// zero-extends it; flags unsupported funct3 values and misaligned accesses.
// Ports: funct3, addr_lo, rdata in; data, legal out. Purely combinational.
module load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        legal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    data     = 32'h0;
    legal    = 1'b0;
    case (funct3)
      F3_LB: begin
        data  = {{24{byte_sel[7]}}, byte_sel};
        legal = 1'b1;
      end
      F3_LBU: begin
        data  = {24'h0, byte_sel};
        legal = 1'b1;
      end
      F3_LH: begin
        data  = {{16{half_sel[15]}}, half_sel};
        legal = !addr_lo[0];
      end
      F3_LHU: begin
        data  = {16'h0, half_sel};
        legal = !addr_lo[0];
      end
      F3_LW: begin
        data  = rdata;
        legal = (addr_lo == 2'b00);
      end
      default: begin
        data  = 32'h0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: drives the GPR write port from retiring ALU results (1-cycle
// latency) and from loads, which wait for variable-latency memory read data.
// Ports: clk, rst (async active-high), bus (slave: retire handshake, memory
// return, a3/we3/wd3, sticky err). in_ready drops while a load is outstanding
// and through its write cycle.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  writeback_stage_if.slave  bus
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);

  wb_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      alo_q, alo_d;
  // Set for the load write cycle so the stage stays stalled through it.
  logic            drain_q, drain_d;
  logic [4:0]      a3_q, a3_d;
  logic            we3_q, we3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic            err_q, err_d;

  logic [31:0]     ext_data;
  logic            ext_legal;
  logic            xfer;

  load_extend u_load_extend (
    .funct3  (f3_q),
    .addr_lo (alo_q),
    .rdata   (bus.mem_rdata),
    .data    (ext_data),
    .legal   (ext_legal)
  );

  assign bus.in_ready = (state_q == WB_IDLE) && !rst;
  assign xfer         = bus.in_valid && bus.in_ready;

  assign bus.a3  = a3_q;
  assign bus.we3 = we3_q;
  assign bus.wd3 = wd3_q;
  assign bus.err = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    alo_d   = alo_q;
    drain_d = 1'b0;
    a3_d    = a3_q;
    we3_d   = 1'b0;
    wd3_d   = wd3_q;
    err_d   = err_q;

    case (state_q)
      WB_IDLE: begin
        // No load is outstanding, so any read data here is spurious.
        if (bus.mem_rvalid) err_d = 1'b1;
        if (xfer) begin
          if (bus.in_is_load) begin
            rd_d    = bus.in_rd;
            f3_d    = bus.in_funct3;
            alo_d   = bus.in_addr_lo;
            cnt_d   = '0;
            state_d = WB_WAIT_LOAD;
          end else if (bus.in_rd != 5'd0) begin
            // a3/wd3 only move when a write actually happens.
            a3_d  = bus.in_rd;
            wd3_d = bus.in_result;
            we3_d = 1'b1;
          end
        end
      end

      WB_WAIT_LOAD: begin
        cnt_d = cnt_q + 1'b1;
        if (drain_q) begin
          // Write cycle of a completed load; data already consumed.
          if (bus.mem_rvalid) err_d = 1'b1;
          state_d = WB_IDLE;
        end else if (bus.mem_rvalid) begin
          if (!ext_legal) begin
            err_d   = 1'b1;
            state_d = WB_IDLE;
          end else if (rd_q == 5'd0) begin
            state_d = WB_IDLE;
          end else begin
            a3_d    = rd_q;
            wd3_d   = ext_data;
            we3_d   = 1'b1;
            drain_d = 1'b1;
          end
        end else if (cnt_q == CW'(LOAD_TIMEOUT - 1)) begin
          // Last allowed wait cycle passed with no data: abort.
          err_d   = 1'b1;
          state_d = WB_IDLE;
        end
      end

      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_IDLE;
      cnt_q   <= '0;
      rd_q    <= 5'd0;
      f3_q    <= 3'd0;
      alo_q   <= 2'd0;
      drain_q <= 1'b0;
      a3_q    <= 5'd0;
      we3_q   <= 1'b0;
      wd3_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      alo_q   <= alo_d;
      drain_q <= drain_d;
      a3_q    <= a3_d;
      we3_q   <= we3_d;
      wd3_q   <= wd3_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  import riscv_pkg::*;

  localparam int TO = 255;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd3;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  wr_t  exp_q[$];

  writeback_stage_if #(.XLEN(32)) bus ();

  writeback_stage #(.XLEN(32), .LOAD_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every GPR write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && bus.we3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we3", {31'h0, bus.we3}, 32'h0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("sb_a3", {27'h0, bus.a3}, {27'h0, e.a3});
        check("sb_wd3", bus.wd3, e.wd3);
      end
    end
  end

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a3 = a;
    e.wd3 = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #1;
    check("rst_a3", {27'h0, bus.a3}, 32'h0);
    check("rst_we3", {31'h0, bus.we3}, 32'h0);
    check("rst_wd3", bus.wd3, 32'h0);
    check("rst_err", {31'h0, bus.err}, 32'h0);
    check("rst_ready", {31'h0, bus.in_ready}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res);
    bus.in_valid = 1'b1;
    bus.in_is_load = 1'b0;
    bus.in_rd = rd;
    bus.in_result = res;
    check("alu_ready", {31'h0, bus.in_ready}, 32'h1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic start_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo);
    bus.in_valid = 1'b1;
    bus.in_is_load = 1'b1;
    bus.in_rd = rd;
    bus.in_funct3 = f3;
    bus.in_addr_lo = alo;
    bus.in_result = 32'hA5A5_A5A5;
    check("ld_accept_ready", {31'h0, bus.in_ready}, 32'h1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_is_load = 1'b0;
  endtask

  // Called in wait cycle 1; read data is presented in wait cycle 'lat'.
  task automatic mem_resp(input int lat, input logic [31:0] d);
    for (int i = 1; i < lat; i++) begin
      check("wait_ready", {31'h0, bus.in_ready}, 32'h0);
      tick();
    end
    check("rvalid_cyc_ready", {31'h0, bus.in_ready}, 32'h0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = d;
    tick();
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic load_write(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] alo, input int lat, input logic [31:0] d,
                            input logic [31:0] expd);
    start_load(rd, f3, alo);
    push(rd, expd);
    mem_resp(lat, d);
    check({tag, "_we3"}, {31'h0, bus.we3}, 32'h1);
    check({tag, "_wd3"}, bus.wd3, expd);
    check({tag, "_ready_wr"}, {31'h0, bus.in_ready}, 32'h0);
    tick();
    check({tag, "_ready_after"}, {31'h0, bus.in_ready}, 32'h1);
    check({tag, "_err"}, {31'h0, bus.err}, 32'h0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_rd = 5'd0;
    bus.in_result = 32'h0;
    bus.in_is_load = 1'b0;
    bus.in_funct3 = 3'd0;
    bus.in_addr_lo = 2'd0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 32'h0;
    #2;
    do_reset();

    // ALU write, 1-cycle latency
    push(5'd5, 32'hDEAD_BEEF);
    alu(5'd5, 32'hDEAD_BEEF);
    check("alu_we3", {31'h0, bus.we3}, 32'h1);
    check("alu_a3", {27'h0, bus.a3}, 32'd5);
    check("alu_wd3", bus.wd3, 32'hDEAD_BEEF);
    tick();
    check("alu_we3_pulse", {31'h0, bus.we3}, 32'h0);

    // Loads of each width
    load_write("lb", 5'd7, F3_LB, 2'd3, 3, 32'h80FF_0000, 32'hFFFF_FF80);
    load_write("lhu", 5'd8, F3_LHU, 2'd2, 2, 32'h9234_5678, 32'h0000_9234);
    load_write("lh", 5'd9, F3_LH, 2'd2, 1, 32'h9234_5678, 32'hFFFF_9234);
    load_write("lbu", 5'd10, F3_LBU, 2'd1, 4, 32'h9234_5678, 32'h0000_0056);
    load_write("lw", 5'd3, F3_LW, 2'd0, 2, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // rd=0: no writes, a3/wd3 hold, FSM returns to IDLE after data
    alu(5'd0, 32'h1234_5678);
    check("r0_alu_we3", {31'h0, bus.we3}, 32'h0);
    check("r0_a3_hold", {27'h0, bus.a3}, 32'd3);
    check("r0_wd3_hold", bus.wd3, 32'hCAFE_F00D);
    start_load(5'd0, F3_LW, 2'd0);
    mem_resp(2, 32'h1111_2222);
    check("r0_lw_we3", {31'h0, bus.we3}, 32'h0);
    check("r0_lw_ready", {31'h0, bus.in_ready}, 32'h1);
    check("r0_err", {31'h0, bus.err}, 32'h0);

    // Misaligned LH
    start_load(5'd11, F3_LH, 2'd1);
    mem_resp(2, 32'h9234_5678);
    check("mis_err", {31'h0, bus.err}, 32'h1);
    check("mis_we3", {31'h0, bus.we3}, 32'h0);
    check("mis_ready", {31'h0, bus.in_ready}, 32'h1);
    tick();
    do_reset();

    // Timeout: no data for TO wait cycles
    start_load(5'd12, F3_LW, 2'd0);
    for (int i = 1; i < TO; i++) tick();
    check("to_last_err", {31'h0, bus.err}, 32'h0);
    check("to_last_ready", {31'h0, bus.in_ready}, 32'h0);
    tick();
    check("to_err", {31'h0, bus.err}, 32'h1);
    check("to_ready", {31'h0, bus.in_ready}, 32'h1);
    check("to_we3", {31'h0, bus.we3}, 32'h0);
    do_reset();

    // Spurious read data while idle
    bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    check("spur_idle_err", {31'h0, bus.err}, 32'h1);
    do_reset();

    // Spurious data on the load-accept cycle; the load still completes later
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h0000_0001;
    start_load(5'd13, F3_LW, 2'd0);
    bus.mem_rvalid = 1'b0;
    check("spur_acc_err", {31'h0, bus.err}, 32'h1);
    check("spur_acc_ready", {31'h0, bus.in_ready}, 32'h0);
    push(5'd13, 32'h0BAD_CAFE);
    mem_resp(2, 32'h0BAD_CAFE);
    check("spur_acc_we3", {31'h0, bus.we3}, 32'h1);
    tick();
    do_reset();

    // Reset mid-load
    push(5'd6, 32'h5555_AAAA);
    alu(5'd6, 32'h5555_AAAA);
    start_load(5'd14, F3_LW, 2'd0);
    tick();
    check("mid_wait_ready", {31'h0, bus.in_ready}, 32'h0);
    do_reset();
    check("mid_ready_post", {31'h0, bus.in_ready}, 32'h1);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    tick();
    bus.mem_rvalid = 1'b0;
    check("mid_late_err", {31'h0, bus.err}, 32'h1);
    check("mid_late_we3", {31'h0, bus.we3}, 32'h0);
    tick();
    tick();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
